// File: rtl/packet_req_fifo.sv
// Per-requester first-word-fall-through packet buffer that feeds one input of the round-robin arbiter.
// Define PKT_FIFO_STORE_FWD_EN to select store-and-forward requests; otherwise requests are cut-through.
module packet_req_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_last,
    output logic                      req,
    output logic                      req_is_last,
    output logic [DATA_WIDTH-1:0]     out_data,
    input  logic                      grant,
    output logic [$clog2(DEPTH):0]    level,
    output logic [$clog2(DEPTH):0]    pkt_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]         pkt_cnt_q, pkt_cnt_d;
    logic [DATA_WIDTH:0] mem_q [DEPTH];
    logic [DATA_WIDTH:0] head_entry;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;
    logic                head_last;

    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        head_entry = mem_q[rd_ptr_q[AW-1:0]];
        head_last  = head_entry[DATA_WIDTH];
    end

    // The full term keeps a packet longer than DEPTH from deadlocking the port.
`ifdef PKT_FIFO_STORE_FWD_EN
    assign req = (pkt_cnt_q != '0) || full;
`else
    assign req = !empty;
`endif

    assign in_ready    = !full;
    assign push        = in_valid && !full;
    assign pop         = grant && req;
    assign out_data    = empty ? '0 : head_entry[DATA_WIDTH-1:0];
    assign req_is_last = !empty && head_last;
    assign level       = wr_ptr_q - rd_ptr_q;
    assign pkt_cnt     = pkt_cnt_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        case ({push && in_last, pop && head_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + (AW+1)'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - (AW+1)'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Storage is never reset; out_data is gated while empty instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
        end
    end

endmodule

// File: tb/tb_packet_req_fifo.sv
// Bench for packet_req_fifo: directed and random traffic against a queue-based packet model.
// Follows PKT_FIFO_STORE_FWD_EN the same way the design does.
module tb_packet_req_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          req;
    logic          req_is_last;
    logic [DW-1:0] out_data;
    logic          grant;
    logic [4:0]    level;
    logic [4:0]    pkt_cnt;

    int checks = 0;
    int errors = 0;
    logic [DW:0] mq[$];

    packet_req_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .req(req), .req_is_last(req_is_last),
        .out_data(out_data), .grant(grant), .level(level), .pkt_cnt(pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pkts();
        int n = 0;
        foreach (mq[i]) if (mq[i][DW]) n++;
        return n;
    endfunction

    function automatic logic model_req();
`ifdef PKT_FIFO_STORE_FWD_EN
        return (model_pkts() != 0) || (mq.size() == DEPTH);
`else
        return mq.size() != 0;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(mq.size() < DEPTH));
        chk({tag, ".req"}, 64'(req), 64'(model_req()));
        chk({tag, ".level"}, 64'(level), 64'(mq.size()));
        chk({tag, ".pkt_cnt"}, 64'(pkt_cnt), 64'(model_pkts()));
        if (mq.size() == 0) begin
            chk({tag, ".out_data_empty"}, 64'(out_data), 64'd0);
            chk({tag, ".req_is_last_empty"}, 64'(req_is_last), 64'd0);
        end else if (model_req()) begin
            chk({tag, ".out_data"}, 64'(out_data), 64'(mq[0][DW-1:0]));
            chk({tag, ".req_is_last"}, 64'(req_is_last), 64'(mq[0][DW]));
        end
    endtask

    // One clock: drive, check current state, advance model across the edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l,
                         input logic g, input string tag);
        logic do_push, do_pop;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        grant    = g;
        check_outputs(tag);
        do_push = v && (mq.size() < DEPTH);
        do_pop  = g && model_req();
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back({l, d});
        #1;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 200 && mq.size() != 0; n++) cycle(1'b0, '0, 1'b0, 1'b1, tag);
        chk({tag, ".level_zero"}, 64'(level), 64'd0);
    endtask

    initial begin
        int pushed;
        logic v, l, g;
        logic [DW-1:0] d;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; grant = 1'b0;
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.req", 64'(req), 64'd0);
        chk("rst.out_data", 64'(out_data), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, i[0], "idle");

        // Three-beat packet under continuous grant
        cycle(1'b1, 32'hA1, 1'b0, 1'b1, "pkt3");
`ifndef PKT_FIFO_STORE_FWD_EN
        chk("pkt3.req_after_first_push", 64'(req), 64'd1);
        chk("pkt3.first_head", 64'(out_data), 64'hA1);
`endif
        cycle(1'b1, 32'hA2, 1'b0, 1'b1, "pkt3");
        cycle(1'b1, 32'hA3, 1'b1, 1'b1, "pkt3");
        drain("pkt3_drain");

        // Fill without grant, then push+pop while full
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'hB0 + i, 1'b0, 1'b0, "fill");
        chk("full.in_ready", 64'(in_ready), 64'd0);
        chk("full.level", 64'(level), 64'd16);
        chk("full.req", 64'(req), 64'd1);
        cycle(1'b1, 32'hEE, 1'b1, 1'b1, "full_pushpop");
        chk("full_pushpop.level", 64'(level), 64'd15);
        chk("full_pushpop.in_ready", 64'(in_ready), 64'd1);
`ifdef PKT_FIFO_STORE_FWD_EN
        chk("guard.req_drops", 64'(req), 64'd0);
`else
        chk("full_pushpop.req", 64'(req), 64'd1);
`endif
        cycle(1'b1, 32'hC0, 1'b1, 1'b0, "close_pkt");
        drain("fill_drain");

`ifdef PKT_FIFO_STORE_FWD_EN
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hD0 + i, 1'b0, 1'b1, "sf_partial");
        chk("sf.no_req", 64'(req), 64'd0);
        cycle(1'b1, 32'hD4, 1'b1, 1'b1, "sf_last");
        chk("sf.req_after_last", 64'(req), 64'd1);
        chk("sf.pkt_cnt", 64'(pkt_cnt), 64'd1);
        drain("sf_drain");
        chk("sf.pkt_cnt_zero", 64'(pkt_cnt), 64'd0);
`endif

        // Random stream of 40 beats with grant gaps, wrapping the pointers
        pushed = 0;
        for (int n = 0; n < 3000 && (pushed < 40 || mq.size() != 0); n++) begin
            v = (pushed < 40) && ($urandom_range(0, 3) != 0);
            d = $urandom;
            l = (pushed == 39) ? 1'b1 : ($urandom_range(0, 4) == 0);
            g = ($urandom_range(0, 2) != 0);
            if (v && mq.size() < DEPTH) pushed++;
            cycle(v, d, l, g, "stream");
        end
        chk("stream.all_pushed", 64'(pushed), 64'd40);
        chk("stream.level_zero", 64'(level), 64'd0);

        // Asynchronous reset in the middle of a packet
        cycle(1'b1, 32'hF1, 1'b0, 1'b0, "mid");
        cycle(1'b1, 32'hF2, 1'b0, 1'b0, "mid");
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        mq.delete();
        chk("arst.level", 64'(level), 64'd0);
        chk("arst.pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("arst.req", 64'(req), 64'd0);
        chk("arst.req_is_last", 64'(req_is_last), 64'd0);
        chk("arst.out_data", 64'(out_data), 64'd0);
        chk("arst.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 32'h51, 1'b0, 1'b1, "post_rst");
        cycle(1'b1, 32'h52, 1'b0, 1'b1, "post_rst");
        cycle(1'b1, 32'h53, 1'b1, 1'b1, "post_rst");
        drain("post_rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_req_fifo.md
# packet_req_fifo

- Per-requester packet buffer placed directly upstream of the round-robin packet arbiter.
- Accepts beats (data + last marker) from one source over a valid/ready handshake and stores them in a first-word-fall-through FIFO.
- Presents the head beat to the arbiter as `req` / `req_is_last` / `out_data`, and pops one beat per cycle while the arbiter's grant bit for this port is high.
- One instance per arbiter input. Its `grant` input is wired to one bit of the arbiter's `grants` vector.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: payload width per beat.
- `DEPTH`, default 16: FIFO entries. Must be a power of two and ≥ 2.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: source beat valid.
- `in_ready` output 1: FIFO can accept a beat.
- `in_data` input DATA_WIDTH: source beat payload.
- `in_last` input 1: beat is the final beat of its packet.
- `req` output 1: head beat available to the arbiter.
- `req_is_last` output 1: head beat carries the last marker.
- `out_data` output DATA_WIDTH: head beat payload.
- `grant` input 1: this port's bit of the arbiter grant vector.
- `level` output $clog2(DEPTH)+1: number of stored beats.
- `pkt_cnt` output $clog2(DEPTH)+1: number of stored complete packets (last markers held in the FIFO).

## Operation

- Storage: DEPTH entries of {last, data}. Pointers are $clog2(DEPTH)+1 bits wide and carry a wrap bit.
  - empty = pointers equal.
  - full = indices equal and wrap bits differ.
- Push = `in_valid && in_ready`, where `in_ready = !full`.
  - Push depends only on full. A pop in the same cycle does not free a slot for a push while full.
- Pop = `grant && req`. A `grant` while `req` is low is ignored, and no state changes.
- `out_data` and `req_is_last` are driven combinationally from the head entry. They are don't-care while `req` is low.
- `level`: +1 on push, −1 on pop, unchanged when both occur.
- `pkt_cnt`: +1 on a push with `in_last`, −1 on a pop with head last, unchanged when both occur.
- Wrap-around: pointers increment modulo 2·DEPTH. There is no special case at the index wrap.
- `req` rule depends on the configuration:
  - Cut-through: `req = !empty`.
  - Store-and-forward: `req = (pkt_cnt != 0) || full`. The `full` term is a deadlock guard for packets longer than DEPTH: the port degrades to cut-through for that packet.
- Reset mid-operation:
  - All contents are discarded.
  - A partially delivered packet is lost.
  - The source is expected to restart on a packet boundary.

## Timing

- Reset values: `in_ready`=1, `req`=0, `req_is_last`=0, `level`=0, `pkt_cnt`=0, `out_data`=0.
  - Memory contents are not reset, so `out_data` is gated to 0 while empty.
- Push-to-req latency is 1 cycle: a beat written at edge N is visible as `req` after edge N.
  - In store-and-forward mode, `req` rises the cycle after the last beat is written.
- Throughput: one push and one pop per cycle sustained when neither full nor empty.
- There is no combinational path from `grant` or `in_valid` to any output. `req` and `in_ready` come from registered state only.
- An empty FIFO with a simultaneous push and pop (pop blocked because `req`=0) performs the push only.

## Configuration

- Macro: `PKT_FIFO_STORE_FWD_EN`.
- Defined: store-and-forward `req` rule, including the full-FIFO deadlock guard.
- Undefined: cut-through `req` rule. `pkt_cnt` is still maintained and output.

## Test plan

- Reset then idle: `rst_n` low for 2 cycles, release → `in_ready`=1, `req`=0, `level`=0, `pkt_cnt`=0 for 5 cycles.
- Cut-through, single 3-beat packet 0xA1, 0xA2, 0xA3 (last on 0xA3), `grant` held high → `req` rises 1 cycle after the first push; `out_data` shows A1, A2, A3 on consecutive cycles; `req_is_last`=1 only with A3; `level` returns to 0.
- Fill with DEPTH=16 beats and no grant → `in_ready`=0 and `level`=16. One cycle with both push and pop attempted → pop only, `level`=15, `in_ready`=1 next cycle.
- Store-and-forward (macro defined):
  - Push 4 beats with no last → `req`=0.
  - Push 5th beat with last → `req`=1 next cycle, `pkt_cnt`=1.
  - Drain under grant → `pkt_cnt`=0 after the last beat pops.
- Store-and-forward deadlock guard: push 16 beats with no last → `req`=1 once full. Grant 1 beat → `req`=0 again (not full, `pkt_cnt`=0).
- Wrap and reset: stream 40 beats through with random grant gaps, checking FIFO order; assert `rst_n` mid-packet → all outputs at reset values asynchronously, and a new packet after release is delivered intact.
